// File: rtl/miner_regfile.sv
// rtl/miner_regfile.sv - regbus register bank for the mining core: job/control/status registers, core pulses, irq.
// Optional CYCLES/FOUNDLAT counters are built when MINER_REGFILE_TIMESTAMP_EN is defined.
module miner_regfile #(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [31:0] CORE_ID = 32'h534D_0001
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              addr_valid_i,
    input  logic              reg_write_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic              reg_ready_o,
    output logic [31:0]       reg_rdata_o,
    output logic              core_start_o,
    output logic              core_abort_o,
    output logic [255:0]      midstate_o,
    output logic [95:0]       data_tail_o,
    output logic [31:0]       nonce_start_o,
    output logic [31:0]       nonce_end_o,
    input  logic              core_busy_i,
    input  logic              core_found_i,
    input  logic [31:0]       core_nonce_i,
    input  logic              core_done_i,
    input  logic              core_hash_tick_i,
    output logic              irq_o
);

    localparam int unsigned WA_W = ADDR_W - 2;

    localparam logic [31:0] W_CTRL    = 32'd0;
    localparam logic [31:0] W_STATUS  = 32'd1;
    localparam logic [31:0] W_NSTART  = 32'd2;
    localparam logic [31:0] W_NEND    = 32'd3;
    localparam logic [31:0] W_GOLDEN  = 32'd4;
    localparam logic [31:0] W_HASHCNT = 32'd5;
    localparam logic [31:0] W_CYCLES  = 32'd6;
    localparam logic [31:0] W_FLAT    = 32'd7;
    localparam logic [31:0] W_MID0    = 32'd8;
    localparam logic [31:0] W_TAIL0   = 32'd16;
    localparam logic [31:0] W_ID      = 32'd31;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic              irq_en_q, irq_en_d;
    logic              found_q, found_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       nonce_start_q, nonce_start_d;
    logic [31:0]       nonce_end_q, nonce_end_d;
    logic [31:0]       golden_q, golden_d;
    logic [31:0]       hashcnt_q, hashcnt_d;
    logic [7:0][31:0]  mid_q, mid_d;
    logic [2:0][31:0]  tail_q, tail_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic              irq_q, irq_d;

    logic              accept;
    logic              wr_en;
    logic [31:0]       wsel;
    logic [31:0]       rsel;
    logic              ctrl_wr;
    logic              stat_wr;
    logic              abort_req;
    logic              start_req;
    logic              start_bad;
    logic              start_ok;
    logic              start_err;
    logic [31:0]       rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^reg_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (addr_valid_i) begin
                    state_d = S_RESP;
                    accept  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register writes land on the same edge that accepts the access.
    always_comb begin
        wr_en     = accept && reg_write_i;
        wsel      = 32'(reg_addr_i[ADDR_W-1:2]);
        ctrl_wr   = wr_en && (wsel == W_CTRL);
        stat_wr   = wr_en && (wsel == W_STATUS);
        abort_req = ctrl_wr && reg_wdata_i[1];
        start_req = ctrl_wr && reg_wdata_i[0] && !reg_wdata_i[1];
        start_bad = core_busy_i || (nonce_end_q < nonce_start_q);
        start_ok  = start_req && !start_bad;
        start_err = start_req && start_bad;

        write_d = accept ? reg_write_i : write_q;
        waddr_d = accept ? reg_addr_i[ADDR_W-1:2] : waddr_q;

        irq_en_d = ctrl_wr ? reg_wdata_i[2] : irq_en_q;

        // Hardware set beats both the W1C clear and the START clear.
        found_d = (found_q && !(stat_wr && reg_wdata_i[1]) && !start_ok) || core_found_i;
        done_d  = (done_q  && !(stat_wr && reg_wdata_i[2]) && !start_ok) || core_done_i;
        err_d   = (err_q   && !(stat_wr && reg_wdata_i[3])) || start_err;

        golden_d = core_found_i ? core_nonce_i : golden_q;

        hashcnt_d = hashcnt_q;
        if (start_ok) begin
            hashcnt_d = '0;
        end else if (core_hash_tick_i && (hashcnt_q != 32'hFFFF_FFFF)) begin
            hashcnt_d = hashcnt_q + 32'd1;
        end

        nonce_start_d = (wr_en && (wsel == W_NSTART)) ? reg_wdata_i : nonce_start_q;
        nonce_end_d   = (wr_en && (wsel == W_NEND))   ? reg_wdata_i : nonce_end_q;

        mid_d = mid_q;
        for (int i = 0; i < 8; i++) begin
            if (wr_en && (wsel == W_MID0 + 32'(i))) begin
                mid_d[i[2:0]] = reg_wdata_i;
            end
        end
        tail_d = tail_q;
        for (int i = 0; i < 3; i++) begin
            if (wr_en && (wsel == W_TAIL0 + 32'(i))) begin
                tail_d[i[1:0]] = reg_wdata_i;
            end
        end

        start_d = start_ok;
        abort_d = abort_req;
        irq_d   = irq_en_q && (found_q || done_q || err_q);
    end

`ifdef MINER_REGFILE_TIMESTAMP_EN
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] flat_q, flat_d;
    logic        flat_run_q, flat_run_d;

    always_comb begin
        cycles_d   = cycles_q + 32'd1;
        flat_d     = flat_q;
        flat_run_d = flat_run_q;
        if (start_ok) begin
            flat_d     = '0;
            flat_run_d = 1'b1;
        end else if (flat_run_q) begin
            if (core_found_i || core_done_i) begin
                flat_run_d = 1'b0;
            end else begin
                flat_d = flat_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycles_q   <= '0;
            flat_q     <= '0;
            flat_run_q <= 1'b0;
        end else begin
            cycles_q   <= cycles_d;
            flat_q     <= flat_d;
            flat_run_q <= flat_run_d;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        rsel  = 32'(waddr_q);
        if ((state_q == S_RESP) && !write_q) begin
            case (rsel)
                W_CTRL:      rdata = {29'd0, irq_en_q, 2'b00};
                W_STATUS:    rdata = {28'd0, err_q, done_q, found_q, core_busy_i};
                W_NSTART:    rdata = nonce_start_q;
                W_NEND:      rdata = nonce_end_q;
                W_GOLDEN:    rdata = golden_q;
                W_HASHCNT:   rdata = hashcnt_q;
`ifdef MINER_REGFILE_TIMESTAMP_EN
                W_CYCLES:    rdata = cycles_q;
                W_FLAT:      rdata = flat_q;
`endif
                W_TAIL0:     rdata = tail_q[0];
                W_TAIL0 + 1: rdata = tail_q[1];
                W_TAIL0 + 2: rdata = tail_q[2];
                W_ID:        rdata = CORE_ID;
                default: begin
                    if ((rsel >= W_MID0) && (rsel < W_MID0 + 32'd8)) begin
                        rdata = mid_q[rsel[2:0]];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            waddr_q       <= '0;
            irq_en_q      <= 1'b0;
            found_q       <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            nonce_start_q <= '0;
            nonce_end_q   <= '0;
            golden_q      <= '0;
            hashcnt_q     <= '0;
            mid_q         <= '0;
            tail_q        <= '0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            waddr_q       <= waddr_d;
            irq_en_q      <= irq_en_d;
            found_q       <= found_d;
            done_q        <= done_d;
            err_q         <= err_d;
            nonce_start_q <= nonce_start_d;
            nonce_end_q   <= nonce_end_d;
            golden_q      <= golden_d;
            hashcnt_q     <= hashcnt_d;
            mid_q         <= mid_d;
            tail_q        <= tail_d;
            start_q       <= start_d;
            abort_q       <= abort_d;
            irq_q         <= irq_d;
        end
    end

    assign reg_ready_o   = (state_q == S_RESP);
    assign reg_rdata_o   = rdata;
    assign core_start_o  = start_q;
    assign core_abort_o  = abort_q;
    assign midstate_o    = mid_q;
    assign data_tail_o   = tail_q;
    assign nonce_start_o = nonce_start_q;
    assign nonce_end_o   = nonce_end_q;
    assign irq_o         = irq_q;

endmodule

// File: doc/miner_regfile.md
Name: miner_regfile

Overview:
- Register-bank slave on the regbus, directly downstream of the AXI4-Lite-to-regbus bridge.
- Decodes regbus reads and writes into the mining core's control, job and status registers.
- Generates start/abort pulses to the hash core and captures its results and hash count.
- Drives a level interrupt to the CPU.

Parameters:
- ADDR_W, 8, width of reg_addr (byte address; bits [1:0] ignored).
- CORE_ID, 32'h534D_0001, constant returned by the ID register.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous reset, active-high
- addr_valid  in  1  regbus access request
- reg_write  in  1  1 = write, 0 = read
- reg_addr  in  ADDR_W  byte address
- reg_wdata  in  32  write data
- reg_ready  out  1  access complete (one-cycle pulse)
- reg_rdata  out  32  read data, valid while reg_ready=1
- core_start  out  1  one-cycle job start pulse
- core_abort  out  1  one-cycle abort pulse
- midstate  out  256  MID[7..0] concatenated, MID7 in MSBs
- data_tail  out  96  TAIL[2..0] concatenated
- nonce_start  out  32  first nonce
- nonce_end  out  32  last nonce, inclusive
- core_busy  in  1  core running (level)
- core_found  in  1  golden nonce pulse
- core_nonce  in  32  nonce, valid with core_found
- core_done  in  1  range exhausted or aborted (pulse)
- core_hash_tick  in  1  one hash evaluated
- irq  out  1  level interrupt

Behaviour:
- Reset: every output and register is 0. State is IDLE. Rst mid-access drops the pending response.
- FSM IDLE -> RESP:
  - Taken when addr_valid=1.
  - Latches reg_write, the word address and wdata, and performs any register write in the same edge.
- FSM RESP -> IDLE:
  - reg_ready=1 for exactly one cycle in RESP.
  - reg_rdata holds the read value; it is 0 for writes.
  - addr_valid is ignored while in RESP.
  - Latency is 1 cycle; maximum throughput is one access per 2 cycles.
- Register map (byte offset):
  - 0x00 CTRL:
    - b0 START (write 1 -> pulse).
    - b1 ABORT (write 1 -> pulse).
    - b2 IRQ_EN (RW).
    - b0 and b1 read 0.
  - 0x04 STATUS:
    - b0 BUSY (RO, mirrors core_busy).
    - b1 FOUND (sticky, W1C).
    - b2 DONE (sticky, W1C).
    - b3 ERR (sticky, W1C).
  - 0x08 NONCE_START RW. 0x0C NONCE_END RW.
  - 0x10 GOLDEN RO. Loaded with core_nonce on every core_found; the last one wins.
  - 0x14 HASHCNT RO. +1 per core_hash_tick, saturates at 0xFFFF_FFFF.
  - 0x20..0x3C MID0..MID7 RW. 0x40..0x48 TAIL0..TAIL2 RW.
  - 0x7C ID RO = CORE_ID.
  - Unmapped: reads return 0, writes are ignored.
- START write accepted:
  - core_start pulses on the cycle after the write edge (registered).
  - FOUND, DONE and HASHCNT clear on that write edge.
- START rejected, setting ERR with no pulse and no clears, if either holds:
  - core_busy=1.
  - NONCE_END < NONCE_START (unsigned).
- NONCE_END == NONCE_START is valid (one nonce).
- START and ABORT both written in one CTRL write: ABORT wins; only core_abort pulses.
- ABORT when idle: pulse still issued, no error.
- Same-cycle hardware set and W1C clear of FOUND/DONE: set wins.
- Writes to job registers while BUSY take effect immediately. Software must not do this.
- irq is registered: irq = IRQ_EN & (FOUND | DONE | ERR). It lags status by 1 cycle.

Optional Feature:
- Macro: MINER_REGFILE_TIMESTAMP_EN.
- Defined:
  - 0x18 CYCLES: free-running 32-bit counter, wraps.
  - 0x1C FOUNDLAT: cycles from accepted START to the first core_found. It stops counting at core_found or core_done and is cleared by START.
- Undefined: 0x18 and 0x1C read 0 and the counters are not synthesized.

Test Plan:
- Write NONCE_START=0x10, NONCE_END=0x20, then CTRL=0x1 -> reg_ready 1 cycle after each addr_valid; core_start one-cycle pulse; reads return 0x10/0x20.
- core_busy=1, write CTRL=0x1 -> no core_start; STATUS reads 0x9. Write STATUS=0x8 -> STATUS reads 0x1.
- NONCE_START=0x30, NONCE_END=0x20, write START -> ERR set, no pulse.
- IRQ_EN=1, core_found with core_nonce=0xDEADBEEF -> GOLDEN=0xDEADBEEF, FOUND=1, irq high 1 cycle later. W1C FOUND in the same cycle as a second core_found -> FOUND stays 1.
- 5 core_hash_tick -> HASHCNT=5. Force counter to 0xFFFF_FFFE plus 3 ticks -> reads 0xFFFF_FFFF.
- Write MID7=0xA5A5_0000 and read unmapped 0x60 -> midstate[255:224]=0xA5A5_0000, rdata=0. Assert Rst during RESP -> reg_ready stays 0 and all registers are 0.
